rob_retire_ctrl: RTL and testbench
==================================

Name: rob_retire_ctrl

Overview:
In-order commit controller for the reorder buffer. Each cycle it examines the EXT_COUNT oldest ROB slots and picks the longest retirable prefix, then drives the ROB consume handshake. It also drives the architectural register-file write ports, sequences single-store commit to the data cache, and raises the branch-mispredict flush/redirect. Sits between the ROB retrieve/flush interface and the register file / store buffer.

Parameters:
DEPTH, 16, ROB depth; must match the ROB.
EXT_COUNT, 4, ROB head window width and maximum retire count per cycle.
RF_WR, 2, number of register-file write ports; limits register-writing retirements per cycle.
DEPTHLOG2, $clog2(DEPTH), ROB index width.
EXTCOUNTLOG2, $clog2(EXT_COUNT), consume_count width.

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
head_idx  in  DEPTHLOG2  ROB index of slot 0 of the window (ROB ext_ptr)
rob_empty  in  1  ROB empty
slot_valid  in  [EXT_COUNT] x 1  slot result written
slot_dest_reg  in  [EXT_COUNT] x 5  destination register
slot_dest_valid  in  [EXT_COUNT] x 1  slot writes a register
slot_result  in  [EXT_COUNT] x 32  result value
slot_is_store  in  [EXT_COUNT] x 1  slot is a store
slot_mispredict  in  [EXT_COUNT] x 1  slot is a mispredicted branch
slot_target  in  [EXT_COUNT] x 32  correct branch target
commit_stall  in  1  external retire inhibit
store_ready  in  1  store buffer accepts the commit this cycle
consume  out  1  ROB consume strobe
consume_count  out  EXTCOUNTLOG2  retired count minus 1
store_commit  out  1  commit request for the store in the group
flush  out  1  ROB flush strobe
flush_idx  out  DEPTHLOG2  ROB index of the mispredicted branch
redirect_valid  out  1  fetch redirect strobe
redirect_pc  out  32  redirect target
rf_we  out  [RF_WR] x 1  register-file write enables
rf_waddr  out  [RF_WR] x 5  register-file write addresses
rf_wdata  out  [RF_WR] x 32  register-file write data
retired_total  out  32  saturating count of retired instructions

Behaviour:
- FSM states: RUN, HOLD. Reset state is RUN; all registered outputs reset to 0.
- consume, consume_count, store_commit, flush, flush_idx, redirect_* are combinational from state and inputs. rf_* and retired_total are registered and update 1 cycle after consume.
- Retire group n is computed in RUN only. n = 0 if commit_stall, rob_empty, or state is HOLD. Otherwise, scanning slot i from 0, a slot is included while all of the following hold:
  - slot_valid[i].
  - Cumulative count of register writes ≤ RF_WR. A register write is slot_dest_valid with dest != 0.
  - At most one store per group. Stores that are included need store_ready = 1; if store_ready = 0 the group stops before that store.
  - A mispredicted branch at slot i is included only if i+1 < EXT_COUNT and slot_valid[i+1]. If so, its delay slot (i+1) is included and the scan ends. If not, the group stops before the branch.
- Outputs from the group:
  - consume = (n > 0); consume_count = n-1 (mod 2^EXTCOUNTLOG2).
  - store_commit = 1 when the group includes a store.
- Flush: when the group ends with a mispredicted branch and its delay slot:
  - flush = redirect_valid = 1 in the same cycle.
  - flush_idx = head_idx + i (mod DEPTH); redirect_pc = slot_target[i].
  - Next state is HOLD for exactly 1 cycle, with no retire, then back to RUN.
- rf ports: retiring register writes are packed in slot order onto ports 0..k-1; unused ports have rf_we = 0. dest 0 is never written.
- retired_total += n each cycle and saturates at 0xFFFFFFFF.
- Wrap-around: all index arithmetic is mod DEPTH; slot order follows window order regardless of head_idx wrap.
- Reset asserted mid-operation: immediate return to RUN with all outputs 0; any in-flight rf write is dropped.

Test Plan:
1. Window of 4 valid ALU ops writing r1,r2,r0,r3 with RF_WR=2 -> first cycle: consume=1, consume_count=2 (r1, r2, r0 retire); next cycle: rf_we=2'b11 with waddr 1,2, and r0 is not written.
2. Slot1 is a store, store_ready=0, slot0 valid -> consume_count=0, store_commit=0. Then raise store_ready -> store commits, store_commit=1.
3. head_idx=14, mispredicted branch in slot1, delay slot valid in slot2, target 0x400 -> consume_count=2, flush=1, flush_idx=15, redirect_pc=0x400. The next cycle is HOLD with consume=0.
4. Mispredicted branch in slot3 -> group stops at 3 entries (consume_count=2), no flush. Next cycle, branch in slot0 with delay slot valid -> flush_idx=head_idx.
5. commit_stall=1 or rob_empty=1 with valid slots -> consume=0 and retired_total unchanged.
6. Assert reset_n=0 during a flush cycle -> outputs immediately 0. After release the state is RUN, and retire resumes on the first valid window.

Source files
------------

// File: rtl/rob_retire_ctrl.sv
// In-order ROB commit controller: selects the longest retirable prefix of the head
// window, packs register writes onto the RF ports, commits one store, raises flush/redirect.
module rob_retire_ctrl #(
    parameter int DEPTH        = 16,
    parameter int EXT_COUNT    = 4,
    parameter int RF_WR        = 2,
    parameter int DEPTHLOG2    = $clog2(DEPTH),
    parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [DEPTHLOG2-1:0]    head_idx,
    input  logic                    rob_empty,
    input  logic [EXT_COUNT-1:0]    slot_valid,
    input  logic [4:0]              slot_dest_reg   [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    slot_dest_valid,
    input  logic [31:0]             slot_result     [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    slot_is_store,
    input  logic [EXT_COUNT-1:0]    slot_mispredict,
    input  logic [31:0]             slot_target     [EXT_COUNT],
    input  logic                    commit_stall,
    input  logic                    store_ready,
    output logic                    consume,
    output logic [EXTCOUNTLOG2-1:0] consume_count,
    output logic                    store_commit,
    output logic                    flush,
    output logic [DEPTHLOG2-1:0]    flush_idx,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic [RF_WR-1:0]        rf_we,
    output logic [4:0]              rf_waddr        [RF_WR],
    output logic [31:0]             rf_wdata        [RF_WR],
    output logic [31:0]             retired_total
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t state, state_next;

    logic [EXT_COUNT-1:0]    wr_bit, next_valid, next_wr, next_st;
    logic [EXT_COUNT-1:0]    take;
    logic                    active, done, in_delay, grp_flush;
    logic [EXTCOUNTLOG2-1:0] br_slot;
    int                      grp_n, wr_cnt, st_cnt, pair_wr, pair_st, fi_sum, k;

    logic [RF_WR-1:0]        rf_we_d;
    logic [4:0]              rf_waddr_d [RF_WR];
    logic [31:0]             rf_wdata_d [RF_WR];
    logic [32:0]             total_sum;

    // Gating on reset_n forces the combinational strobes low while reset is held.
    assign active     = reset_n && (state == RUN) && !commit_stall && !rob_empty;
    assign next_valid = slot_valid >> 1;
    assign next_wr    = wr_bit >> 1;
    assign next_st    = slot_is_store >> 1;

    always_comb begin
        for (int i = 0; i < EXT_COUNT; i++) begin
            wr_bit[i] = slot_dest_valid[i] && (slot_dest_reg[i] != 5'd0);
        end
    end

    // NOTE: the scan carries running counts from slot to slot inside one evaluation,
    // so these are blocking assignments, and every variable gets its default first
    // so no latch is inferred.
    always_comb begin
        grp_n     = 0;
        wr_cnt    = 0;
        st_cnt    = 0;
        pair_wr   = 0;
        pair_st   = 0;
        in_delay  = 1'b0;
        grp_flush = 1'b0;
        br_slot   = '0;
        take      = '0;
        done      = !active;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (!done) begin
                if (in_delay) begin
                    // Delay slot of the mispredicted branch: its limits were checked with the branch.
                    take[i] = 1'b1;
                    grp_n++;
                    done = 1'b1;
                end else if (!slot_valid[i]) begin
                    done = 1'b1;
                end else if (slot_mispredict[i]) begin
                    pair_wr = int'(wr_bit[i]) + int'(next_wr[i]);
                    pair_st = int'(slot_is_store[i]) + int'(next_st[i]);
                    if (next_valid[i] && (wr_cnt + pair_wr <= RF_WR) &&
                        (st_cnt + pair_st <= 1) && ((pair_st == 0) || store_ready)) begin
                        take[i]   = 1'b1;
                        grp_n++;
                        wr_cnt    = wr_cnt + pair_wr;
                        st_cnt    = st_cnt + pair_st;
                        in_delay  = 1'b1;
                        grp_flush = 1'b1;
                        br_slot   = EXTCOUNTLOG2'(i);
                    end else begin
                        done = 1'b1;
                    end
                end else if (wr_cnt + int'(wr_bit[i]) > RF_WR) begin
                    done = 1'b1;
                end else if (slot_is_store[i] && ((st_cnt > 0) || !store_ready)) begin
                    done = 1'b1;
                end else begin
                    take[i] = 1'b1;
                    grp_n++;
                    wr_cnt  = wr_cnt + int'(wr_bit[i]);
                    st_cnt  = st_cnt + int'(slot_is_store[i]);
                end
            end
        end
    end

    always_comb begin
        fi_sum = int'(head_idx) + int'(br_slot);
        if (fi_sum >= DEPTH) fi_sum = fi_sum - DEPTH;
        consume        = (grp_n > 0);
        consume_count  = EXTCOUNTLOG2'(grp_n - 1);
        store_commit   = (st_cnt > 0);
        flush          = grp_flush;
        redirect_valid = grp_flush;
        flush_idx      = grp_flush ? DEPTHLOG2'(fi_sum) : '0;
        redirect_pc    = grp_flush ? slot_target[br_slot] : 32'd0;
    end

    // Register writes of the retiring slots, packed in slot order onto ports 0..k-1.
    always_comb begin
        k       = 0;
        rf_we_d = '0;
        for (int p = 0; p < RF_WR; p++) begin
            rf_waddr_d[p] = '0;
            rf_wdata_d[p] = '0;
        end
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (take[i] && wr_bit[i]) begin
                for (int p = 0; p < RF_WR; p++) begin
                    if (p == k) begin
                        rf_we_d[p]    = 1'b1;
                        rf_waddr_d[p] = slot_dest_reg[i];
                        rf_wdata_d[p] = slot_result[i];
                    end
                end
                k++;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (grp_flush) state_next = HOLD;
            HOLD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign total_sum = {1'b0, retired_total} + 33'(grp_n);

    // NOTE: every register here, including the RF port outputs, takes the async reset,
    // so an RF write in flight when reset arrives is dropped rather than delivered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            rf_we         <= '0;
            retired_total <= '0;
            for (int p = 0; p < RF_WR; p++) begin
                rf_waddr[p] <= '0;
                rf_wdata[p] <= '0;
            end
        end else begin
            state         <= state_next;
            rf_we         <= rf_we_d;
            retired_total <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
            for (int p = 0; p < RF_WR; p++) begin
                rf_waddr[p] <= rf_waddr_d[p];
                rf_wdata[p] <= rf_wdata_d[p];
            end
        end
    end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Bench for rob_retire_ctrl: directed table, hand sequences for flush/HOLD/reset,
// and random windows checked against a prefix-legality reference model.
module tb_rob_retire_ctrl;

    localparam int DEPTH = 16;
    localparam int EXT   = 4;
    localparam int RF_WR = 2;

    typedef struct {
        logic [3:0]           head;
        logic                 empty, stall, ready;
        logic [EXT-1:0]       valid, dv, st, mis;
        logic [EXT-1:0][4:0]  dest;
        logic [EXT-1:0][31:0] result, target;
    } in_t;

    typedef struct {
        string name;
        in_t   in;
        int    n;
        bit    st;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    in_t         cur;
    logic [4:0]  d_dest   [EXT];
    logic [31:0] d_result [EXT];
    logic [31:0] d_target [EXT];

    logic             consume, store_commit, flush, redirect_valid;
    logic [1:0]       consume_count;
    logic [3:0]       flush_idx;
    logic [31:0]      redirect_pc, retired_total;
    logic [RF_WR-1:0] rf_we;
    logic [4:0]       rf_waddr [RF_WR];
    logic [31:0]      rf_wdata [RF_WR];

    int total = 0;
    int bad   = 0;

    // reference state
    bit          m_hold;
    longint      m_total;
    bit          e_we   [RF_WR];
    logic [4:0]  e_addr [RF_WR];
    logic [31:0] e_data [RF_WR];

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < EXT; i++) begin
            d_dest[i]   = cur.dest[i];
            d_result[i] = cur.result[i];
            d_target[i] = cur.target[i];
        end
    end

    rob_retire_ctrl dut (
        .clock(clock), .reset_n(reset_n), .head_idx(cur.head), .rob_empty(cur.empty),
        .slot_valid(cur.valid), .slot_dest_reg(d_dest), .slot_dest_valid(cur.dv),
        .slot_result(d_result), .slot_is_store(cur.st), .slot_mispredict(cur.mis),
        .slot_target(d_target), .commit_stall(cur.stall), .store_ready(cur.ready),
        .consume(consume), .consume_count(consume_count), .store_commit(store_commit),
        .flush(flush), .flush_idx(flush_idx), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retired_total(retired_total)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t blank();
        in_t v;
        v.head = '0; v.empty = 0; v.stall = 0; v.ready = 1;
        v.valid = '0; v.dv = '0; v.st = '0; v.mis = '0;
        for (int i = 0; i < EXT; i++) begin
            v.dest[i]   = 5'(i + 1);
            v.result[i] = 32'hA000_0000 + 32'(i);
            v.target[i] = 32'h1000 + 32'(i * 16);
        end
        return v;
    endfunction

    // A prefix of length len may retire if every slot is valid, it needs at most RF_WR
    // writes to non-zero registers, holds at most one store (and only with store_ready),
    // and any mispredicted branch in it sits just before its last entry (the delay slot).
    function automatic bit legal(input in_t v, input int len);
        int w = 0;
        int s = 0;
        for (int j = 0; j < len; j++) begin
            if (!v.valid[j]) return 1'b0;
            if (v.dv[j] && v.dest[j] != 0) w++;
            if (v.st[j]) s++;
            if (v.mis[j] && j != len - 2) return 1'b0;
        end
        if (w > RF_WR || s > 1 || (s == 1 && !v.ready)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model(input in_t v, input bit hold, output int n, output bit st,
                                  output bit fl, output int fi);
        n = 0; st = 0; fl = 0; fi = 0;
        if (!(hold || v.stall || v.empty)) begin
            for (int len = 1; len <= EXT; len++) if (legal(v, len)) n = len;
        end
        for (int j = 0; j < n; j++) if (v.st[j]) st = 1;
        if (n >= 2 && v.mis[n-2]) begin
            fl = 1;
            fi = (int'(v.head) + n - 2) % DEPTH;
        end
    endfunction

    // Drives one window from just after a rising edge, checks the strobes at the falling
    // edge and the registered outputs just after the next rising edge.
    task automatic run_cycle(input in_t v, output bit s_consume, output int s_cnt,
                             output bit s_st, output bit s_fl, output int s_fi);
        int n; bit st; bit fl; int fi; int kk;
        cur = v;
        model(v, m_hold, n, st, fl, fi);
        @(negedge clock);
        s_consume = consume; s_cnt = int'(consume_count); s_st = store_commit;
        s_fl = flush; s_fi = int'(flush_idx);
        check("consume", 64'(consume), 64'(n > 0));
        check("consume_count", 64'(consume_count), 64'((n - 1) & 3));
        check("store_commit", 64'(store_commit), 64'(st));
        check("flush", 64'(flush), 64'(fl));
        check("redirect_valid", 64'(redirect_valid), 64'(fl));
        if (fl) begin
            check("flush_idx", 64'(flush_idx), 64'(fi));
            check("redirect_pc", 64'(redirect_pc), 64'(v.target[n-2]));
        end
        @(posedge clock);
        #1;
        m_hold = fl;
        m_total = m_total + n;
        if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
        kk = 0;
        for (int p = 0; p < RF_WR; p++) e_we[p] = 0;
        for (int j = 0; j < n; j++) begin
            if (v.dv[j] && v.dest[j] != 0) begin
                e_we[kk] = 1; e_addr[kk] = v.dest[j]; e_data[kk] = v.result[j];
                kk++;
            end
        end
        for (int p = 0; p < RF_WR; p++) begin
            check("rf_we", 64'(rf_we[p]), 64'(e_we[p]));
            if (e_we[p]) begin
                check("rf_waddr", 64'(rf_waddr[p]), 64'(e_addr[p]));
                check("rf_wdata", 64'(rf_wdata[p]), 64'(e_data[p]));
            end
        end
        check("retired_total", 64'(retired_total), m_total);
    endtask

    function automatic in_t rand_in();
        in_t v;
        v = blank();
        v.head  = 4'($urandom_range(0, 15));
        v.empty = ($urandom_range(0, 9) == 0);
        v.stall = ($urandom_range(0, 9) == 0);
        v.ready = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < EXT; i++) begin
            v.valid[i]  = ($urandom_range(0, 9) < 8);
            v.dv[i]     = $urandom_range(0, 1);
            v.dest[i]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.result[i] = $urandom;
            v.target[i] = $urandom;
            v.st[i]     = ($urandom_range(0, 4) == 0);
            v.mis[i]    = ($urandom_range(0, 5) == 0);
            if (i > 0 && v.mis[i-1]) v.mis[i] = 1'b0;
        end
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        in_t v;
        vec_t t;
        bit s_c; int s_n; bit s_s; bit s_f; int s_i;

        // directed table: {name, window, expected retire count, expected store_commit}
        v = blank(); v.valid = 4'hF; v.dv = 4'hF;
        v.dest[0] = 1; v.dest[1] = 2; v.dest[2] = 0; v.dest[3] = 3;
        t.name = "alu_r0";          t.in = v; t.n = 3; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.st = 4'b0010; v.ready = 0;
        t.name = "store_blocked";   t.in = v; t.n = 1; t.st = 0; vecs.push_back(t);
        v.ready = 1;
        t.name = "store_ready";     t.in = v; t.n = 4; t.st = 1; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.mis = 4'b1000;
        t.name = "branch_slot3";    t.in = v; t.n = 3; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.stall = 1;
        t.name = "stall";           t.in = v; t.n = 0; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.empty = 1;
        t.name = "empty";           t.in = v; t.n = 0; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'b1110;
        t.name = "slot0_invalid";   t.in = v; t.n = 0; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.st = 4'b0101;
        t.name = "two_stores";      t.in = v; t.n = 2; t.st = 1; vecs.push_back(t);
        v = blank(); v.valid = 4'b0001; v.mis = 4'b0001;
        t.name = "branch_no_delay"; t.in = v; t.n = 0; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.dv = 4'b0111;
        t.name = "write_limit";     t.in = v; t.n = 2; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'b1011;
        t.name = "hole";            t.in = v; t.n = 2; t.st = 0; vecs.push_back(t);
        v = blank(); v.valid = 4'hF; v.st = 4'b0001; v.ready = 0;
        t.name = "store_head_wait"; t.in = v; t.n = 0; t.st = 0; vecs.push_back(t);

        // reset state
        cur = blank(); cur.valid = 4'hF;
        m_hold = 0; m_total = 0;
        for (int p = 0; p < RF_WR; p++) e_we[p] = 0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_consume", 64'(consume), 64'd0);
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_total", 64'(retired_total), 64'd0);
        cur = blank();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[j]) begin
            run_cycle(vecs[j].in, s_c, s_n, s_s, s_f, s_i);
            check({vecs[j].name, "_consume"}, 64'(s_c), 64'(vecs[j].n > 0));
            if (vecs[j].n > 0) check({vecs[j].name, "_count"}, 64'(s_n), 64'(vecs[j].n - 1));
            check({vecs[j].name, "_store"}, 64'(s_s), 64'(vecs[j].st));
            check({vecs[j].name, "_flush"}, 64'(s_f), 64'd0);
        end

        // r1, r2 retire on ports 0/1 one cycle later; r0 is never written
        run_cycle(vecs[0].in, s_c, s_n, s_s, s_f, s_i);
        check("seq1_rf_we", 64'(rf_we), 64'b11);
        check("seq1_waddr0", 64'(rf_waddr[0]), 64'd1);
        check("seq1_waddr1", 64'(rf_waddr[1]), 64'd2);

        // branch in slot1 with head at 14 wraps to index 15, then one HOLD cycle
        v = blank(); v.head = 4'd14; v.valid = 4'hF; v.mis = 4'b0010; v.target[1] = 32'h400;
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);
        check("seq3_count", 64'(s_n), 64'd2);
        check("seq3_flush", 64'(s_f), 64'd1);
        check("seq3_idx", 64'(s_i), 64'd15);
        v = blank(); v.valid = 4'hF;
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);
        check("seq3_hold", 64'(s_c), 64'd0);
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);
        check("seq3_resume", 64'(s_n), 64'd3);

        // branch in slot0 with delay slot: flush_idx equals head_idx
        v = blank(); v.head = 4'd9; v.valid = 4'hF; v.mis = 4'b0001;
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);
        check("seq4_count", 64'(s_n), 64'd1);
        check("seq4_idx", 64'(s_i), 64'd9);
        v = blank();
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);

        // reset during a flush cycle
        v = blank(); v.head = 4'd3; v.valid = 4'hF; v.mis = 4'b0001; v.dv = 4'hF;
        cur = v;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_consume", 64'(consume), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redirect", 64'(redirect_valid), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_total", 64'(retired_total), 64'd0);
        cur = blank();
        @(negedge clock);
        reset_n = 1'b1;
        m_hold = 0; m_total = 0;
        for (int p = 0; p < RF_WR; p++) e_we[p] = 0;
        @(posedge clock);
        #1;
        v = blank(); v.valid = 4'hF;
        run_cycle(v, s_c, s_n, s_s, s_f, s_i);
        check("rst_resume", 64'(s_c), 64'd1);

        for (int r = 0; r < 500; r++) begin
            run_cycle(rand_in(), s_c, s_n, s_s, s_f, s_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
